parallel_adder_seq_ctrl: RTL and testbench

//  Sequencer for the bit-serial parallel_adder_16x4 datapath. Accepts one set of M
//  N-bit operands per transaction (valid/ready), clears the adder, then streams
//  bit-slices LSB-first. Waits out the adder latency, captures the sum and holds it
//  on a valid/ready output. Sits between the operand source and the adder instance.

---
 rtl/parallel_adder_pkg.sv | 34 +++
 rtl/pa_slice_shifter.sv | 52 +++++
 rtl/parallel_adder_seq_ctrl.sv | 168 ++++++++++++++++
 tb/tb_parallel_adder_seq_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parallel_adder_pkg.sv
// Shared definitions for the parallel-adder sequencer.
//   - default operand count, operand width, result width and adder latency
//   - controller state encoding
//   - counter-width helpers (never narrower than one bit)
package parallel_adder_pkg;

    localparam int M_DEF         = 16;
    localparam int N_DEF         = 4;
    localparam int RES_W_DEF     = 8;
    localparam int ADDER_LAT_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Slice counter runs 0..N-1.
    function automatic int slice_cw(input int n);
        return cw(n);
    endfunction

    // Wait counter holds values up to ADDER_LAT.
    function automatic int lat_cw(input int lat);
        return cw(lat + 1);
    endfunction

endpackage

// File: rtl/pa_slice_shifter.sv
// Operand store and bit-slice generator for the parallel-adder sequencer.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   load          capture the operand bus (operand k at [k*N +: N])
//   advance       shift every operand right by one bit
//   operands      M*N-bit operand bus
//   slice         current LSB of every operand; operand k drives bit M-1-k
module pa_slice_shifter
    import parallel_adder_pkg::*;
#(
    parameter int M = M_DEF,
    parameter int N = N_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             advance,
    input  logic [M*N-1:0]   operands,
    output logic [M-1:0]     slice
);

    logic [M*N-1:0] op_q;
    logic [M*N-1:0] op_d;

    always_comb begin
        op_d = op_q;
        if (load) begin
            op_d = operands;
        end else if (advance) begin
            for (int k = 0; k < M; k++) begin
                op_d[k*N +: N] = op_q[k*N +: N] >> 1;
            end
        end
    end

    // Operand 0 lands on the MSB of the slice, matching the adder's input order.
    always_comb begin
        slice = '0;
        for (int k = 0; k < M; k++) begin
            slice[M-1-k] = op_q[k*N];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q <= '0;
        end else begin
            op_q <= op_d;
        end
    end

endmodule

// File: rtl/parallel_adder_seq_ctrl.sv
// Sequencer for the bit-serial parallel adder datapath.
// Accepts one operand set per valid/ready transaction, clears the adder, streams
// N bit-slices LSB first, waits out the adder latency, then captures the sum and
// holds it on a valid/ready output until accepted.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   in_valid/in_ready operand handshake (ready only while idle)
//   operands          M*N-bit operand bus, operand k at [k*N +: N]
//   data_bits         slice to the adder, operand k on bit M-1-k
//   adder_rst         active-high clear to the adder
//   adder_result      sum from the adder
//   result/out_valid  captured sum, held until out_ready
//   out_ready         consumer accepts result
//   busy              high whenever not idle
//
// state     | meaning
// ST_IDLE   | adder held clear, waiting for an operand set
// ST_CLEAR  | one cycle of adder clear after accept
// ST_STREAM | N cycles driving slices 0..N-1
// ST_WAIT   | ADDER_LAT cycles for the adder pipeline, capture in the last
// ST_DONE   | result presented until out_ready
module parallel_adder_seq_ctrl
    import parallel_adder_pkg::*;
#(
    parameter int M         = M_DEF,
    parameter int N         = N_DEF,
    parameter int RES_W     = RES_W_DEF,
    parameter int ADDER_LAT = ADDER_LAT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [M*N-1:0]     operands,
    output logic [M-1:0]       data_bits,
    output logic               adder_rst,
    input  logic [RES_W-1:0]   adder_result,
    output logic [RES_W-1:0]   result,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy
);

    localparam int SLICE_CW = slice_cw(N);
    localparam int LAT_CW   = lat_cw(ADDER_LAT);

    state_e                state_q, state_d;
    logic [SLICE_CW-1:0]   slice_cnt_q, slice_cnt_d;
    logic [LAT_CW-1:0]     wait_cnt_q, wait_cnt_d;
    logic [M-1:0]          data_bits_q, data_bits_d;
    logic                  adder_rst_q, adder_rst_d;
    logic [RES_W-1:0]      result_q, result_d;
    logic                  out_valid_q, out_valid_d;

    logic                  sh_load;
    logic                  sh_advance;
    logic [M-1:0]          sh_slice;

    pa_slice_shifter #(
        .M (M),
        .N (N)
    ) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .load     (sh_load),
        .advance  (sh_advance),
        .operands (operands),
        .slice    (sh_slice)
    );

    // Outputs are registered one cycle ahead: data_bits_d carries the slice that
    // the adder must see during the next state, and the shifter advances as soon
    // as that slice has been taken.
    always_comb begin
        state_d     = state_q;
        slice_cnt_d = slice_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        data_bits_d = data_bits_q;
        adder_rst_d = adder_rst_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        sh_load     = 1'b0;
        sh_advance  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                adder_rst_d = 1'b1;
                data_bits_d = '0;
                if (in_valid) begin
                    sh_load     = 1'b1;
                    slice_cnt_d = '0;
                    state_d     = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                adder_rst_d = 1'b0;
                data_bits_d = sh_slice;
                sh_advance  = 1'b1;
                slice_cnt_d = '0;
                state_d     = ST_STREAM;
            end
            ST_STREAM: begin
                adder_rst_d = 1'b0;
                if (slice_cnt_q == SLICE_CW'(N - 1)) begin
                    data_bits_d = '0;
                    wait_cnt_d  = LAT_CW'(ADDER_LAT - 1);
                    state_d     = ST_WAIT;
                end else begin
                    data_bits_d = sh_slice;
                    sh_advance  = 1'b1;
                    slice_cnt_d = slice_cnt_q + 1'b1;
                end
            end
            ST_WAIT: begin
                data_bits_d = '0;
                adder_rst_d = 1'b0;
                if (wait_cnt_q == '0) begin
                    result_d    = adder_result;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    adder_rst_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                adder_rst_d = 1'b1;
                data_bits_d = '0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            slice_cnt_q <= '0;
            wait_cnt_q  <= '0;
            data_bits_q <= '0;
            adder_rst_q <= 1'b1;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            slice_cnt_q <= slice_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            data_bits_q <= data_bits_d;
            adder_rst_q <= adder_rst_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign data_bits = data_bits_q;
    assign adder_rst = adder_rst_q;
    assign result    = result_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_parallel_adder_seq_ctrl.sv
// Bench for parallel_adder_seq_ctrl with a behavioural bit-serial adder standing
// in for parallel_adder_16x4 (popcount of each slice weighted by its position,
// two cycles from last slice to valid sum).
module tb_parallel_adder_seq_ctrl;

    localparam int M         = 16;
    localparam int N         = 4;
    localparam int RES_W     = 8;
    localparam int ADDER_LAT = 2;
    localparam int EXP_LAT   = N + ADDER_LAT + 2;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [M*N-1:0]     operands;
    logic [M-1:0]       data_bits;
    logic               adder_rst;
    logic [RES_W-1:0]   adder_result;
    logic [RES_W-1:0]   result;
    logic               out_valid;
    logic               out_ready;
    logic               busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    parallel_adder_seq_ctrl #(
        .M         (M),
        .N         (N),
        .RES_W     (RES_W),
        .ADDER_LAT (ADDER_LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .operands     (operands),
        .data_bits    (data_bits),
        .adder_rst    (adder_rst),
        .adder_result (adder_result),
        .result       (result),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit-serial adder stand-in: accumulator plus one output register.
    logic [RES_W-1:0] acc;
    int               bit_idx;
    always @(posedge clk or negedge rst) begin
        if (!rst || adder_rst) begin
            acc          <= '0;
            bit_idx      <= 0;
            adder_result <= '0;
        end else begin
            acc          <= acc + RES_W'($countones(data_bits) << bit_idx);
            if (bit_idx < 16) bit_idx <= bit_idx + 1;
            adder_result <= acc;
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [M*N-1:0] pack_ops(input int unsigned v [M]);
        logic [M*N-1:0] p;
        p = '0;
        for (int k = 0; k < M; k++) p[k*N +: N] = N'(v[k]);
        return p;
    endfunction

    function automatic logic [RES_W-1:0] ref_sum(input logic [M*N-1:0] ops);
        int s;
        s = 0;
        for (int k = 0; k < M; k++) s += int'(ops[k*N +: N]);
        return RES_W'(s % (1 << RES_W));
    endfunction

    function automatic logic [M-1:0] ref_slice(input logic [M*N-1:0] ops, input int i);
        logic [M-1:0] s;
        s = '0;
        for (int k = 0; k < M; k++) s[M-1-k] = ops[k*N + i];
        return s;
    endfunction

    // ---------------- stimulus driver ----------------
    // Runs one transaction: accepts ops, records STREAM slices, holds out_ready
    // low for 'hold' cycles after out_valid, then completes the handshake.
    task automatic run_op(input logic [M*N-1:0] ops, input int hold,
                          output logic [RES_W-1:0] res, output int lat,
                          output logic [N*M-1:0] sl, output bit timeout,
                          output bit held_ok);
        int cyc;
        sl      = '0;
        timeout = 1'b0;
        held_ok = 1'b1;
        @(posedge clk); #1;
        operands  = ops;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (out_valid !== 1'b1) begin
            if (cyc >= 2 && cyc <= N + 1) sl[(cyc-2)*M +: M] = data_bits;
            if (cyc > 60) begin
                timeout = 1'b1;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        lat = cyc;
        res = result;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || result !== res || busy !== 1'b1) held_ok = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (result !== '0) $display("FAIL reset_result: got %0d want 0", result); else pass_cnt++;
        total_cnt++; if (adder_rst !== 1'b1) $display("FAIL reset_adder_rst: got %b want 1", adder_rst); else pass_cnt++;
        total_cnt++; if (data_bits !== '0) $display("FAIL reset_data_bits: got %h want 0", data_bits); else pass_cnt++;
    endtask

    task automatic test_basic_52;
        int unsigned v [M] = '{2,1,2,3,4,6,7,1,2,1,2,3,4,6,7,1};
        logic [M*N-1:0]   ops;
        logic [RES_W-1:0] res;
        logic [N*M-1:0]   sl;
        int lat;
        bit to, hk;
        ops = pack_ops(v);
        run_op(ops, 0, res, lat, sl, to, hk);
        total_cnt++; if (to) $display("FAIL basic_timeout: out_valid never rose"); else pass_cnt++;
        total_cnt++; if (lat != EXP_LAT) $display("FAIL basic_latency: got %0d want %0d", lat, EXP_LAT); else pass_cnt++;
        total_cnt++; if (res !== 8'd52) $display("FAIL basic_result: got %0d want 52", res); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_one_cycle_valid: got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL basic_back_to_idle: got %b want 1", in_ready); else pass_cnt++;
    endtask

    task automatic test_hold_240;
        int unsigned v [M];
        logic [RES_W-1:0] res;
        logic [N*M-1:0]   sl;
        int lat;
        bit to, hk;
        for (int k = 0; k < M; k++) v[k] = 15;
        run_op(pack_ops(v), 5, res, lat, sl, to, hk);
        total_cnt++; if (to) $display("FAIL hold_timeout: out_valid never rose"); else pass_cnt++;
        total_cnt++; if (res !== 8'd240) $display("FAIL hold_result: got %0d want 240", res); else pass_cnt++;
        total_cnt++; if (!hk) $display("FAIL hold_stable: result/out_valid/busy changed while out_ready low, got 0 want 1"); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0 || in_ready !== 1'b1) $display("FAIL hold_idle_after_ready: busy=%b in_ready=%b want 0/1", busy, in_ready); else pass_cnt++;
    endtask

    task automatic test_slices;
        int unsigned v [M];
        logic [M*N-1:0]   ops;
        logic [RES_W-1:0] res;
        logic [N*M-1:0]   sl;
        logic [N*M-1:0]   exp_sl;
        int lat;
        bit to, hk;
        for (int k = 0; k < M; k++) v[k] = 0;
        v[0] = 8;
        ops = pack_ops(v);
        exp_sl = {16'h8000, 16'h0000, 16'h0000, 16'h0000};
        run_op(ops, 0, res, lat, sl, to, hk);
        total_cnt++; if (sl !== exp_sl) $display("FAIL slices_op0: got %h want %h", sl, exp_sl); else pass_cnt++;
        total_cnt++; if (res !== 8'd8) $display("FAIL slices_op0_result: got %0d want 8", res); else pass_cnt++;
        v[0]  = 0;
        v[15] = 1;
        ops = pack_ops(v);
        run_op(ops, 1, res, lat, sl, to, hk);
        total_cnt++; if (sl[M-1:0] !== 16'h0001) $display("FAIL slices_op15_first: got %h want 0001", sl[M-1:0]); else pass_cnt++;
        total_cnt++; if (res !== 8'd1) $display("FAIL slices_op15_result: got %0d want 1", res); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int unsigned v1 [M] = '{2,1,2,3,4,6,7,1,2,1,2,3,4,6,7,1};
        int unsigned v2 [M];
        logic [RES_W-1:0] r1, r2;
        bit ready_low_ok, to;
        int cyc;
        for (int k = 0; k < M; k++) v2[k] = 15;
        ready_low_ok = 1'b1;
        to = 1'b0;
        @(posedge clk); #1;
        operands = pack_ops(v1);
        in_valid = 1'b1;
        @(posedge clk); #1;
        operands = pack_ops(v2);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 60) begin
            if (in_ready !== 1'b0) ready_low_ok = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 60) to = 1'b1;
        r1 = result;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 60) to = 1'b1;
        r2 = result;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total_cnt++; if (to) $display("FAIL b2b_timeout: out_valid never rose"); else pass_cnt++;
        total_cnt++; if (!ready_low_ok) $display("FAIL b2b_in_ready_busy: got 1 want 0 while busy"); else pass_cnt++;
        total_cnt++; if (r1 !== 8'd52) $display("FAIL b2b_first: got %0d want 52", r1); else pass_cnt++;
        total_cnt++; if (r2 !== 8'd240) $display("FAIL b2b_second: got %0d want 240", r2); else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        int unsigned v [M];
        logic [RES_W-1:0] res;
        logic [N*M-1:0]   sl;
        int lat;
        bit to, hk, spurious;
        for (int k = 0; k < M; k++) v[k] = 9;
        @(posedge clk); #1;
        operands = pack_ops(v);
        in_valid = 1'b1;
        @(posedge clk); #1;          // CLEAR
        in_valid = 1'b0;
        @(posedge clk); #1;          // STREAM cycle 1
        @(posedge clk); #1;          // STREAM cycle 2
        rst = 1'b0;
        #1;
        total_cnt++; if (busy !== 1'b0 || in_ready !== 1'b1) $display("FAIL midrst_state: busy=%b in_ready=%b want 0/1", busy, in_ready); else pass_cnt++;
        total_cnt++; if (data_bits !== '0 || adder_rst !== 1'b1) $display("FAIL midrst_adder_if: data_bits=%h adder_rst=%b want 0/1", data_bits, adder_rst); else pass_cnt++;
        total_cnt++; if (result !== '0 || out_valid !== 1'b0) $display("FAIL midrst_result: result=%0d out_valid=%b want 0/0", result, out_valid); else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b1;
        spurious = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) spurious = 1'b1;
        end
        total_cnt++; if (spurious) $display("FAIL midrst_no_valid: got out_valid=1 want 0"); else pass_cnt++;
        for (int k = 0; k < M; k++) v[k] = 0;
        run_op(pack_ops(v), 0, res, lat, sl, to, hk);
        total_cnt++; if (to || res !== '0) $display("FAIL midrst_next_op: got %0d (timeout=%b) want 0", res, to); else pass_cnt++;
    endtask

    task automatic test_random;
        logic [M*N-1:0]   ops;
        logic [RES_W-1:0] res;
        logic [N*M-1:0]   sl;
        logic [N*M-1:0]   exp_sl;
        int lat, errs_res, errs_lat, errs_sl, errs_hold;
        bit to, hk;
        errs_res = 0; errs_lat = 0; errs_sl = 0; errs_hold = 0;
        for (int t = 0; t < 16; t++) begin
            for (int k = 0; k < M; k++) ops[k*N +: N] = N'($urandom_range(0, (1 << N) - 1));
            for (int i = 0; i < N; i++) exp_sl[i*M +: M] = ref_slice(ops, i);
            run_op(ops, int'($urandom_range(0, 3)), res, lat, sl, to, hk);
            if (to || res !== ref_sum(ops)) begin
                errs_res++;
                $display("  op %0d: got %0d want %0d", t, res, ref_sum(ops));
            end
            if (lat != EXP_LAT) errs_lat++;
            if (sl !== exp_sl) errs_sl++;
            if (!hk) errs_hold++;
        end
        total_cnt++; if (errs_res != 0) $display("FAIL random_results: got %0d bad sums want 0", errs_res); else pass_cnt++;
        total_cnt++; if (errs_lat != 0) $display("FAIL random_latency: got %0d bad latencies want 0", errs_lat); else pass_cnt++;
        total_cnt++; if (errs_sl != 0) $display("FAIL random_slices: got %0d bad slice streams want 0", errs_sl); else pass_cnt++;
        total_cnt++; if (errs_hold != 0) $display("FAIL random_hold: got %0d unstable holds want 0", errs_hold); else pass_cnt++;
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        operands  = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b1;
        test_basic_52();
        test_hold_240();
        test_slices();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
